// File: rtl/tour_cmd_pkg.sv
// Shared types and encodings for the knight's-tour command sequencer.
// Holds the FSM state enum, command/response codes and the leg struct.
package tour_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VERT,
        ST_WAIT_V,
        ST_HORZ,
        ST_WAIT_H
    } state_e;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_MOVE_FF = 4'h3;
    localparam logic [3:0] OP_ABORT   = 4'hF;

    localparam logic [7:0] HD_N = 8'h00;
    localparam logic [7:0] HD_W = 8'h3F;
    localparam logic [7:0] HD_S = 8'h7F;
    localparam logic [7:0] HD_E = 8'hBF;

    localparam logic [7:0] RESP_ACK     = 8'hA5;
    localparam logic [7:0] RESP_DONE    = 8'h5A;
    localparam logic [7:0] RESP_ILLEGAL = 8'hEE;

    typedef struct packed {
        logic [7:0] heading;
        logic [3:0] squares;
    } leg_t;

    function automatic leg_t mk_leg(input logic [7:0] heading, input logic [3:0] squares);
        leg_t l;
        l.heading = heading;
        l.squares = squares;
        return l;
    endfunction

    function automatic logic [15:0] mk_cmd(input logic [3:0] opcode, input leg_t leg);
        return {opcode, leg};
    endfunction

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Command/response handshake between UART wrapper, sequencer and command processor.
// master = sequencer side, slave = environment (UART wrapper + consumer) side.
interface tour_cmd_seq_if;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;

    modport master (
        input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output cmd, cmd_rdy, resp
    );

    modport slave (
        output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  cmd, cmd_rdy, resp
    );
endinterface

// File: rtl/tour_move_decode.sv
// One-hot knight move -> vertical leg then horizontal leg; purely combinational.
// Anything other than exactly one bit set decodes as illegal with zeroed legs.
module tour_move_decode
    import tour_cmd_pkg::*;
(
    input  logic [7:0] move,
    output leg_t       vert_leg,
    output leg_t       horz_leg,
    output logic       legal
);

    always_comb begin
        vert_leg = '0;
        horz_leg = '0;
        legal    = 1'b1;
        case (move)
            8'h01: begin vert_leg = mk_leg(HD_N, 4'd2); horz_leg = mk_leg(HD_W, 4'd1); end
            8'h02: begin vert_leg = mk_leg(HD_N, 4'd2); horz_leg = mk_leg(HD_E, 4'd1); end
            8'h04: begin vert_leg = mk_leg(HD_N, 4'd1); horz_leg = mk_leg(HD_W, 4'd2); end
            8'h08: begin vert_leg = mk_leg(HD_S, 4'd1); horz_leg = mk_leg(HD_W, 4'd2); end
            8'h10: begin vert_leg = mk_leg(HD_S, 4'd2); horz_leg = mk_leg(HD_W, 4'd1); end
            8'h20: begin vert_leg = mk_leg(HD_S, 4'd2); horz_leg = mk_leg(HD_E, 4'd1); end
            8'h40: begin vert_leg = mk_leg(HD_S, 4'd1); horz_leg = mk_leg(HD_E, 4'd2); end
            8'h80: begin vert_leg = mk_leg(HD_N, 4'd1); horz_leg = mk_leg(HD_E, 4'd2); end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: UART pass-through when idle, two legs per move on tour.
// cmd/cmd_rdy/resp are combinational; each leg holds until clr_cmd_rdy, then waits for send_resp.
module tour_cmd_seq
    import tour_cmd_pkg::*;
#(
    parameter int NUM_MOVES    = 24,
    parameter int MV_W         = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1,
    parameter int FANFARE_MODE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_tour,
    input  logic [7:0]      move,
    output logic [MV_W-1:0] mv_indx,
    output logic            tour_busy,
    output logic            tour_done,
    output logic            tour_abort,
    tour_cmd_seq_if.master  cif
);

    localparam logic [MV_W-1:0] LAST_IDX = MV_W'(NUM_MOVES - 1);

    state_e          state_q;
    logic [MV_W-1:0] mv_indx_q;
    logic            done_q;
    logic            abort_q;

    leg_t vert_leg;
    leg_t horz_leg;
    logic legal;

    tour_move_decode u_decode (
        .move     (move),
        .vert_leg (vert_leg),
        .horz_leg (horz_leg),
        .legal    (legal)
    );

    logic       busy;
    logic       last_move;
    logic       abort_req;
    logic       illegal;
    logic [3:0] horz_op;

    assign busy      = (state_q != ST_IDLE);
    assign last_move = (mv_indx_q == LAST_IDX);
    assign abort_req = busy && cif.cmd_rdy_UART && (cif.cmd_UART[15:12] == OP_ABORT);
    assign illegal   = (state_q == ST_VERT) && !legal && !abort_req;

    always_comb begin
        horz_op = OP_MOVE;
        if (FANFARE_MODE == 1 || (FANFARE_MODE == 2 && last_move)) begin
            horz_op = OP_MOVE_FF;
        end
    end

    always_comb begin
        cif.cmd     = cif.cmd_UART;
        cif.cmd_rdy = cif.cmd_rdy_UART;
        cif.resp    = RESP_ACK;
        case (state_q)
            ST_IDLE: ;
            ST_VERT, ST_WAIT_V: begin
                cif.cmd     = mk_cmd(OP_MOVE, vert_leg);
                cif.cmd_rdy = (state_q == ST_VERT) && !illegal && !abort_req;
                if (illegal) cif.resp = RESP_ILLEGAL;
            end
            default: begin
                cif.cmd     = mk_cmd(horz_op, horz_leg);
                cif.cmd_rdy = (state_q == ST_HORZ) && !abort_req;
                if (state_q == ST_WAIT_H && last_move) cif.resp = RESP_DONE;
            end
        endcase
    end

    // Abort beats illegal-move detection, which beats the normal handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mv_indx_q <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (abort_req) begin
                state_q   <= ST_IDLE;
                mv_indx_q <= '0;
                abort_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_tour) begin
                            state_q   <= ST_VERT;
                            mv_indx_q <= '0;
                        end
                    end
                    ST_VERT: begin
                        if (!legal) begin
                            state_q   <= ST_IDLE;
                            mv_indx_q <= '0;
                            abort_q   <= 1'b1;
                        end else if (cif.clr_cmd_rdy) begin
                            state_q <= ST_WAIT_V;
                        end
                    end
                    ST_WAIT_V: if (cif.send_resp) state_q <= ST_HORZ;
                    ST_HORZ:   if (cif.clr_cmd_rdy) state_q <= ST_WAIT_H;
                    ST_WAIT_H: begin
                        if (cif.send_resp) begin
                            if (last_move) begin
                                state_q   <= ST_IDLE;
                                mv_indx_q <= '0;
                                done_q    <= 1'b1;
                            end else begin
                                state_q   <= ST_VERT;
                                mv_indx_q <= mv_indx_q + MV_W'(1);
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign mv_indx    = mv_indx_q;
    assign tour_busy  = busy;
    assign tour_done  = done_q;
    assign tour_abort = abort_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench: DUT a (24 moves, fanfare every horizontal leg), DUT b (4 moves, final fanfare).
module tb_tour_cmd_seq;

    logic clk;
    logic rst_n;

    logic       start_a, start_b;
    logic [7:0] move_a, move_b;
    logic [4:0] mv_a;
    logic [1:0] mv_b;
    logic       busy_a, done_a, abort_a;
    logic       busy_b, done_b, abort_b;

    tour_cmd_seq_if if_a ();
    tour_cmd_seq_if if_b ();

    tour_cmd_seq #(.NUM_MOVES(24), .FANFARE_MODE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start_tour(start_a), .move(move_a), .mv_indx(mv_a),
        .tour_busy(busy_a), .tour_done(done_a), .tour_abort(abort_a), .cif(if_a)
    );

    tour_cmd_seq #(.NUM_MOVES(4), .FANFARE_MODE(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start_tour(start_b), .move(move_b), .mv_indx(mv_b),
        .tour_busy(busy_b), .tour_done(done_b), .tour_abort(abort_b), .cif(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int legs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a negedge with DUT a in VERT; leaves at a negedge after the move's final send_resp.
    task automatic a_move(input int i, input logic [7:0] mv, input logic [15:0] ev, input logic [15:0] eh);
        move_a = mv;
        #1;
        chk("a_vert_cmd", if_a.cmd, ev);
        chk("a_vert_rdy", if_a.cmd_rdy, 1);
        chk("a_mv_indx", mv_a, i);
        if (if_a.cmd_rdy) legs++;
        if_a.clr_cmd_rdy = 1'b1; step(); if_a.clr_cmd_rdy = 1'b0; #1;
        chk("a_waitv_rdy", if_a.cmd_rdy, 0);
        if_a.send_resp = 1'b1; step(); if_a.send_resp = 1'b0; #1;
        chk("a_horz_cmd", if_a.cmd, eh);
        chk("a_horz_rdy", if_a.cmd_rdy, 1);
        if (if_a.cmd_rdy) legs++;
        if_a.clr_cmd_rdy = 1'b1; step(); if_a.clr_cmd_rdy = 1'b0; #1;
        chk("a_waith_resp", if_a.resp, (i == 23) ? 8'h5A : 8'hA5);
        chk("a_waith_done", done_a, 0);
        if_a.send_resp = 1'b1; step(); if_a.send_resp = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        move_a = 8'h10; move_b = 8'h80;
        if_a.cmd_UART = 16'hBEAD; if_a.cmd_rdy_UART = 1'b1;
        if_a.clr_cmd_rdy = 1'b0; if_a.send_resp = 1'b0;
        if_b.cmd_UART = 16'h0000; if_b.cmd_rdy_UART = 1'b0;
        if_b.clr_cmd_rdy = 1'b0; if_b.send_resp = 1'b0;

        // Reset and pass-through
        @(negedge clk); #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_mv", mv_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_abort", abort_a, 0);
        chk("rst_cmd", if_a.cmd, 16'hBEAD);
        chk("rst_rdy", if_a.cmd_rdy, 1);
        rst_n = 1'b1;
        step(); #1;
        chk("idle_cmd", if_a.cmd, 16'hBEAD);
        chk("idle_rdy", if_a.cmd_rdy, 1);
        chk("idle_resp", if_a.resp, 8'hA5);
        chk("idle_busy", busy_a, 0);
        if_a.cmd_UART = 16'h0000; if_a.cmd_rdy_UART = 1'b0;

        // Full 24-move tour: 12 x S2/W1 then 12 x N2/W1
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int i = 0; i < 24; i++) begin
            a_move(i, (i < 12) ? 8'h10 : 8'h01, (i < 12) ? 16'h27F2 : 16'h2002, 16'h33F1);
        end
        #1;
        chk("a_done_pulse", done_a, 1);
        chk("a_end_busy", busy_a, 0);
        chk("a_end_mv", mv_a, 0);
        chk("a_legs", legs, 48);
        step(); #1;
        chk("a_done_clear", done_a, 0);

        // Abort from WAIT_V of move 1
        start_a = 1'b1; step(); start_a = 1'b0;
        a_move(0, 8'h10, 16'h27F2, 16'h33F1);
        #1;
        chk("ab_mv1", mv_a, 1);
        if_a.clr_cmd_rdy = 1'b1; step(); if_a.clr_cmd_rdy = 1'b0;
        if_a.cmd_UART = 16'hF000; if_a.cmd_rdy_UART = 1'b1; #1;
        chk("ab_not_fwd_cmd", if_a.cmd, 16'h27F2);
        chk("ab_not_fwd_rdy", if_a.cmd_rdy, 0);
        step(); if_a.cmd_rdy_UART = 1'b0; if_a.cmd_UART = 16'h0000; #1;
        chk("ab_pulse", abort_a, 1);
        chk("ab_busy", busy_a, 0);
        chk("ab_mv", mv_a, 0);
        chk("ab_nodone", done_a, 0);
        step(); #1;
        chk("ab_clear", abort_a, 0);

        // Abort and clr_cmd_rdy together in VERT: abort wins
        start_a = 1'b1; step(); start_a = 1'b0;
        if_a.clr_cmd_rdy = 1'b1; if_a.cmd_UART = 16'hF123; if_a.cmd_rdy_UART = 1'b1;
        step();
        if_a.clr_cmd_rdy = 1'b0; if_a.cmd_UART = 16'h0000; if_a.cmd_rdy_UART = 1'b0; #1;
        chk("pri_abort", abort_a, 1);
        chk("pri_busy", busy_a, 0);

        // Illegal moves: zero-hot, then multi-hot
        move_a = 8'h00;
        start_a = 1'b1; step(); start_a = 1'b0; #1;
        chk("ill0_resp", if_a.resp, 8'hEE);
        chk("ill0_rdy", if_a.cmd_rdy, 0);
        step(); #1;
        chk("ill0_abort", abort_a, 1);
        chk("ill0_busy", busy_a, 0);
        move_a = 8'h03;
        start_a = 1'b1; step(); start_a = 1'b0; #1;
        chk("ill3_resp", if_a.resp, 8'hEE);
        chk("ill3_rdy", if_a.cmd_rdy, 0);
        step(); #1;
        chk("ill3_abort", abort_a, 1);
        chk("ill3_busy", busy_a, 0);

        // DUT b: fanfare only on final horizontal leg
        start_b = 1'b1; step(); start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("b_vert_cmd", if_b.cmd, 16'h2001);
            chk("b_mv", mv_b, i);
            if_b.clr_cmd_rdy = 1'b1; step(); if_b.clr_cmd_rdy = 1'b0;
            if_b.send_resp = 1'b1; step(); if_b.send_resp = 1'b0; #1;
            chk("b_horz_cmd", if_b.cmd, (i == 3) ? 16'h3BF2 : 16'h2BF2);
            if_b.clr_cmd_rdy = 1'b1; step(); if_b.clr_cmd_rdy = 1'b0; #1;
            chk("b_resp", if_b.resp, (i == 3) ? 8'h5A : 8'hA5);
            if_b.send_resp = 1'b1; step(); if_b.send_resp = 1'b0;
        end
        #1;
        chk("b_done", done_b, 1);
        chk("b_busy", busy_b, 0);
        chk("b_abort", abort_b, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
